// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared stage-entry type and constants for the decode hazard logic
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int         REG_W    = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             load;
        logic             mc;
    } stage_entry_t;

    localparam int           ENTRY_W      = $bits(stage_entry_t);
    localparam stage_entry_t ENTRY_BUBBLE = '0;

    // Multicycle results are written by their own unit, never forwarded.
    function automatic logic [REG_W-1:0] fwd_rd(input stage_entry_t e);
        return (e.valid && e.we && !e.mc) ? e.rd : REG_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Brief    : ID-stage instruction info in, per-stage RD / stall status out
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if;
    logic       id_valid_in;
    logic [4:0] id_rd_addr_in;
    logic       id_rd_we_in;
    logic       id_is_load_in;
    logic       id_is_mc_in;
    logic [4:0] id_rs1_addr_in;
    logic [4:0] id_rs2_addr_in;
    logic       id_rs1_used_in;
    logic       id_rs2_used_in;
    logic       flush_in;
    logic [4:0] is_rd_addr_out;
    logic [4:0] ex_rd_addr_out;
    logic [4:0] wb_rd_addr_out;
    logic       stall_out;
    logic       mc_busy_out;

    modport master (
        output id_valid_in, id_rd_addr_in, id_rd_we_in, id_is_load_in, id_is_mc_in,
               id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in, flush_in,
        input  is_rd_addr_out, ex_rd_addr_out, wb_rd_addr_out, stall_out, mc_busy_out
    );

    modport slave (
        input  id_valid_in, id_rd_addr_in, id_rd_we_in, id_is_load_in, id_is_mc_in,
               id_rs1_addr_in, id_rs2_addr_in, id_rs1_used_in, id_rs2_used_in, flush_in,
        output is_rd_addr_out, ex_rd_addr_out, wb_rd_addr_out, stall_out, mc_busy_out
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : hz_stage_reg
// Brief    : Single pipeline-stage entry with bubble-insert and clear
// Revision : 1.0 - initial release
// ============================================================================
module hz_stage_reg
    import hazard_scoreboard_pkg::*;
(
    input  wire          clock_in,
    input  wire          reset_n_in,
    input  stage_entry_t d,
    input  wire          bubble,
    input  wire          clear,
    output stage_entry_t q
);

    // bubble models a stall slot, clear models a squash; both leave an empty entry
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            q <= ENTRY_BUBBLE;
        end else if (clear || bubble) begin
            q <= ENTRY_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Tracks in-flight RDs through IS/EX/WB and raises decode stalls
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MC_LATENCY = 4    // legal range 1..15
) (
    input  wire                 clock_in,
    input  wire                 reset_n_in,
    hazard_scoreboard_if.slave  bus
);

    localparam logic [3:0] MC_LOAD = 4'(MC_LATENCY);

    stage_entry_t id_entry;
    stage_entry_t is_q;
    stage_entry_t ex_q;
    stage_entry_t wb_q;

    logic [3:0]       mc_cnt;
    logic [3:0]       mc_cnt_nxt;
    logic [REG_W-1:0] mc_rd;
    logic [REG_W-1:0] mc_rd_nxt;

    logic hit_rs1;
    logic hit_rs2;
    logic load_use;
    logic mc_active;
    logic mc_data;
    logic mc_struct;
    logic stall;
    logic advance;
    logic unused_load;

    function automatic logic src_hit(input logic used, input logic [REG_W-1:0] addr,
                                     input stage_entry_t e);
        return used && (addr != REG_ZERO) && e.valid && e.we && (addr == e.rd);
    endfunction

    always_comb begin
        id_entry       = ENTRY_BUBBLE;
        id_entry.valid = bus.id_valid_in;
        id_entry.rd    = bus.id_rd_addr_in;
        id_entry.we    = bus.id_rd_we_in && (bus.id_rd_addr_in != REG_ZERO);
        id_entry.load  = bus.id_is_load_in;
        id_entry.mc    = bus.id_is_mc_in;
    end

    assign hit_rs1   = src_hit(bus.id_rs1_used_in, bus.id_rs1_addr_in, is_q);
    assign hit_rs2   = src_hit(bus.id_rs2_used_in, bus.id_rs2_addr_in, is_q);
    assign load_use  = is_q.valid && is_q.load && (hit_rs1 || hit_rs2);
    assign mc_active = (mc_cnt != 4'd0);
    assign mc_data   = mc_active && (mc_rd != REG_ZERO) &&
                       ((bus.id_rs1_addr_in == mc_rd) || (bus.id_rs2_addr_in == mc_rd));
    assign mc_struct = mc_active && bus.id_is_mc_in;
    assign stall     = bus.id_valid_in && (load_use || mc_data || mc_struct) && !bus.flush_in;
    assign advance   = bus.id_valid_in && !stall && !bus.flush_in;

    always_comb begin
        mc_cnt_nxt = (mc_cnt != 4'd0) ? (mc_cnt - 4'd1) : 4'd0;
        mc_rd_nxt  = mc_rd;
        if (bus.flush_in && is_q.valid && is_q.mc) begin
            mc_cnt_nxt = 4'd0;
        end else if (advance && id_entry.mc && id_entry.we) begin
            mc_cnt_nxt = MC_LOAD;
            mc_rd_nxt  = id_entry.rd;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mc_cnt <= 4'd0;
            mc_rd  <= REG_ZERO;
        end else begin
            mc_cnt <= mc_cnt_nxt;
            mc_rd  <= mc_rd_nxt;
        end
    end

    hz_stage_reg u_is (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .d          (id_entry),
        .bubble     (stall),
        .clear      (bus.flush_in),
        .q          (is_q)
    );

    hz_stage_reg u_ex (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .d          (is_q),
        .bubble     (1'b0),
        .clear      (bus.flush_in),
        .q          (ex_q)
    );

    hz_stage_reg u_wb (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .d          (ex_q),
        .bubble     (1'b0),
        .clear      (1'b0),
        .q          (wb_q)
    );

    // Load tag only matters in IS; downstream copies ride along unused.
    assign unused_load = ex_q.load ^ wb_q.load;

    assign bus.is_rd_addr_out = fwd_rd(is_q);
    assign bus.ex_rd_addr_out = fwd_rd(ex_q);
    assign bus.wb_rd_addr_out = fwd_rd(wb_q);
    assign bus.stall_out      = stall;
    assign bus.mc_busy_out    = mc_active;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed scenarios plus randomized traffic against a reference model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int LAT = 4;

    logic clock_in = 1'b0;
    logic reset_n_in;
    always #5 clock_in = ~clock_in;

    hazard_scoreboard_if bus ();

    hazard_scoreboard #(.MC_LATENCY(LAT)) dut (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: index 0=IS, 1=EX, 2=WB.
    bit mv[3];
    int mrd[3];
    bit mwe[3];
    bit mld[3];
    bit mmc[3];
    int mcnt;
    int mmcrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            mv[s] = 0; mrd[s] = 0; mwe[s] = 0; mld[s] = 0; mmc[s] = 0;
        end
        mcnt  = 0;
        mmcrd = 0;
    endtask

    function automatic int exp_rd(input int s);
        return (mv[s] && mwe[s] && !mmc[s]) ? mrd[s] : 0;
    endfunction

    function automatic bit exp_stall();
        int  r1 = int'(bus.id_rs1_addr_in);
        int  r2 = int'(bus.id_rs2_addr_in);
        bit  h1 = bus.id_rs1_used_in && r1 != 0 && mv[0] && mwe[0] && r1 == mrd[0];
        bit  h2 = bus.id_rs2_used_in && r2 != 0 && mv[0] && mwe[0] && r2 == mrd[0];
        bit  lu = mv[0] && mld[0] && (h1 || h2);
        bit  md = mcnt > 0 && mmcrd != 0 && (r1 == mmcrd || r2 == mmcrd);
        bit  ms = mcnt > 0 && bus.id_is_mc_in;
        return bus.id_valid_in && (lu || md || ms) && !bus.flush_in;
    endfunction

    task automatic model_advance();
        bit st = exp_stall();
        bit fl = bus.flush_in;
        int rd = int'(bus.id_rd_addr_in);
        bit we = bus.id_rd_we_in && rd != 0;
        if (fl && mv[0] && mmc[0]) mcnt = 0;
        else if (bus.id_valid_in && bus.id_is_mc_in && we && !st && !fl) begin
            mcnt  = LAT;
            mmcrd = rd;
        end else if (mcnt > 0) mcnt = mcnt - 1;
        mv[2] = mv[1]; mrd[2] = mrd[1]; mwe[2] = mwe[1]; mld[2] = mld[1]; mmc[2] = mmc[1];
        if (fl) mv[1] = 0;
        else begin
            mv[1] = mv[0]; mrd[1] = mrd[0]; mwe[1] = mwe[0]; mld[1] = mld[0]; mmc[1] = mmc[0];
        end
        if (fl || st || !bus.id_valid_in) begin
            mv[0] = 0; mrd[0] = 0; mwe[0] = 0; mld[0] = 0; mmc[0] = 0;
        end else begin
            mv[0] = 1; mrd[0] = rd; mwe[0] = we;
            mld[0] = bus.id_is_load_in; mmc[0] = bus.id_is_mc_in;
        end
    endtask

    task automatic set_id(input bit v, input int rd, input bit we, input bit ld, input bit mc,
                          input int rs1, input bit u1, input int rs2, input bit u2);
        bus.id_valid_in    = v;
        bus.id_rd_addr_in  = 5'(rd);
        bus.id_rd_we_in    = we;
        bus.id_is_load_in  = ld;
        bus.id_is_mc_in    = mc;
        bus.id_rs1_addr_in = 5'(rs1);
        bus.id_rs1_used_in = u1;
        bus.id_rs2_addr_in = 5'(rs2);
        bus.id_rs2_used_in = u2;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush_in = 0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_is"}, bus.is_rd_addr_out, 0);
        chk({tag, "_ex"}, bus.ex_rd_addr_out, 0);
        chk({tag, "_wb"}, bus.wb_rd_addr_out, 0);
        chk({tag, "_stall"}, bus.stall_out, 0);
        chk({tag, "_busy"}, bus.mc_busy_out, 0);
    endtask

    // Compare every output with the model, then advance both across one edge.
    task automatic cycle();
        @(negedge clock_in);
        chk("m_stall", bus.stall_out, exp_stall());
        chk("m_busy", bus.mc_busy_out, mcnt != 0);
        chk("m_is_rd", bus.is_rd_addr_out, exp_rd(0));
        chk("m_ex_rd", bus.ex_rd_addr_out, exp_rd(1));
        chk("m_wb_rd", bus.wb_rd_addr_out, exp_rd(2));
        model_advance();
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        reset_n_in = 1'b0;
        idle();
        model_reset();
        #3;
        chk_outs_zero("rst_during");
        repeat (2) @(posedge clock_in);
        #1;
        reset_n_in = 1'b1;
        #2;
        chk_outs_zero("rst_after");

        // Load-use: exactly one stall cycle, load then visible in EX.
        set_id(1, 5, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 6, 1, 0, 0, 5, 1, 1, 1);
        #2;
        chk("lu_stall", bus.stall_out, 1);
        chk("lu_is5", bus.is_rd_addr_out, 5);
        cycle();
        #2;
        chk("lu_release", bus.stall_out, 0);
        chk("lu_ex5", bus.ex_rd_addr_out, 5);
        chk("lu_bubble", bus.is_rd_addr_out, 0);
        cycle();

        // ALU x7 walks IS -> EX -> WB under independent traffic.
        set_id(1, 7, 1, 0, 0, 1, 1, 2, 1);
        cycle();
        set_id(1, 11, 1, 0, 0, 2, 1, 3, 1);
        #2; chk("alu_is7", bus.is_rd_addr_out, 7); chk("alu_nostall0", bus.stall_out, 0);
        cycle();
        set_id(1, 12, 1, 0, 0, 3, 1, 4, 1);
        #2; chk("alu_ex7", bus.ex_rd_addr_out, 7); chk("alu_nostall1", bus.stall_out, 0);
        cycle();
        set_id(1, 13, 1, 0, 0, 4, 1, 1, 1);
        #2; chk("alu_wb7", bus.wb_rd_addr_out, 7); chk("alu_nostall2", bus.stall_out, 0);
        cycle();
        idle();
        repeat (3) cycle();

        // MUL x9 then a reader: LAT stall cycles, x9 never forwarded.
        set_id(1, 9, 1, 0, 1, 0, 0, 0, 0);
        cycle();
        set_id(1, 14, 1, 0, 0, 9, 1, 0, 0);
        for (int i = 0; i < LAT; i++) begin
            #2;
            chk("mcd_stall", bus.stall_out, 1);
            chk("mcd_is", bus.is_rd_addr_out, 0);
            chk("mcd_ex", bus.ex_rd_addr_out, 0);
            chk("mcd_wb", bus.wb_rd_addr_out, 0);
            cycle();
        end
        #2;
        chk("mcd_release", bus.stall_out, 0);
        chk("mcd_idle", bus.mc_busy_out, 0);
        cycle();
        idle();
        repeat (3) cycle();

        // Back-to-back MULs: structural stall, second enters when busy falls.
        set_id(1, 9, 1, 0, 1, 0, 0, 0, 0);
        cycle();
        set_id(1, 10, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < LAT; i++) begin
            #2;
            chk("mcs_stall", bus.stall_out, 1);
            chk("mcs_busy", bus.mc_busy_out, 1);
            cycle();
        end
        #2;
        chk("mcs_release", bus.stall_out, 0);
        chk("mcs_notbusy", bus.mc_busy_out, 0);
        cycle();
        idle();
        #2;
        chk("mcs_second_busy", bus.mc_busy_out, 1);
        chk("mcs_second_is", bus.is_rd_addr_out, 0);
        repeat (6) cycle();

        // Flush beats a load-use stall.
        set_id(1, 4, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 3, 1, 1, 0, 0, 0, 0, 0);
        cycle();
        set_id(1, 8, 1, 0, 0, 3, 1, 0, 0);
        bus.flush_in = 1;
        #2;
        chk("fl_nostall", bus.stall_out, 0);
        cycle();
        idle();
        #2;
        chk("fl_is", bus.is_rd_addr_out, 0);
        chk("fl_ex", bus.ex_rd_addr_out, 0);
        chk("fl_wb4", bus.wb_rd_addr_out, 4);
        cycle();
        repeat (2) cycle();

        // Asynchronous reset in the middle of a countdown.
        set_id(1, 9, 1, 0, 1, 0, 0, 0, 0);
        cycle();
        idle();
        repeat (2) cycle();
        #2;
        chk("ar_busy_before", bus.mc_busy_out, 1);
        reset_n_in = 1'b0;
        #1;
        chk_outs_zero("ar_during");
        model_reset();
        @(posedge clock_in);
        #1;
        reset_n_in = 1'b1;
        #2;
        chk_outs_zero("ar_after");

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            bit ld = ($urandom_range(0, 3) == 0);
            set_id($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   ld, !ld && ($urandom_range(0, 5) == 0),
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            bus.flush_in = ($urandom_range(0, 11) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
